// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
//   ser_state_e  : IDLE / RUN / DONE encoding shared by serial arithmetic units
//   SER_WIDTH_DEF: default operand width
package serial_subtractor_pkg;

    localparam int SER_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ser_state_e;

endpackage

// File: rtl/serial_subtractor_fs.sv
// Combinational one-bit full subtractor: d = a - b - bin, with borrow out.
//   a, b, bin : minuend bit, subtrahend bit, borrow in
//   d, bout   : difference bit, borrow out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
//   clk, reset      : rising-edge clock, async active-high reset
//   start, A, B, Bin: request and operands, sampled in IDLE or DONE
//   busy            : high while bits are being processed (RUN)
//   done            : one-cycle pulse when Diff/Bout have been updated
//   Diff, Bout      : registered difference and borrow out, held between ops
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    ser_state_e         state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [WIDTH-1:0]   sd_q, sd_d;
    logic               br_q, br_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;

    logic               d_bit;
    logic               b_next;

    full_subtractor u_fs (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .bin  (br_q),
        .d    (d_bit),
        .bout (b_next)
    );

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sd_d    = sd_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sa_d    = A;
                    sb_d    = B;
                    br_d    = Bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sd_d  = {d_bit, sd_q[WIDTH-1:1]};
                br_d  = b_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Take the final bit straight from the cell so the
                    // result is complete on the same edge that leaves RUN.
                    diff_d  = {d_bit, sd_q[WIDTH-1:1]};
                    bout_d  = b_next;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sd_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sd_q    <= sd_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    // Status outputs decode straight from the state register, so they are
    // glitch-free and mutually exclusive by construction.
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign Diff = diff_q;
    assign Bout = bout_q;

endmodule
